// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 widths, burst/response codes and write-master FSM states
package axi4_pkg;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  typedef enum logic [1:0] {FIXED, INCR, WRAP, RSVD} burst_e;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_e;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wm_state_e;
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  endfunction
endpackage

// File: rtl/axi4_write_master_if.sv
// axi4_write_master_if: AXI4 write address, data and response channels between master and slave
interface axi4_write_master_if;
  import axi4_pkg::*;
  logic              AWVALID;
  logic              AWREADY;
  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              WVALID;
  logic              WREADY;
  logic [ID_W-1:0]   WID;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  modport master (
    output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    output WVALID, WID, WDATA, WSTRB, WLAST, BREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP
  );
  modport slave (
    input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    input  WVALID, WID, WDATA, WSTRB, WLAST, BREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP
  );
endinterface

// File: rtl/axi4_wm_cmd_check.sv
// axi4_wm_cmd_check: combinational legality check of a write command (size, burst type, wrap length)
module axi4_wm_cmd_check
  import axi4_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] burst,
  input  logic [7:0] len,
  output logic       legal
);
  always_comb legal = size <= 3'd2 && burst != RSVD && (burst != WRAP || wrap_len_ok(len));
endmodule

// File: rtl/axi4_write_master.sv
// axi4_write_master: single-outstanding AXI4 write master turning one command plus a beat stream into AW/W/B.
// Define AXI4_WM_TIMEOUT_EN to add a B-response watchdog that gives up after TIMEOUT_CYCLES cycles.
module axi4_write_master
  import axi4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [STRB_W-1:0]   wd_strb,
  axi4_write_master_if.master axi,
  output logic                done_valid,
  output logic [ID_W-1:0]     done_id,
  output logic [1:0]          done_resp,
  output logic                done_id_err
);
  wm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              cmd_legal, timeout, w_hs, last;

  axi4_wm_cmd_check u_cmd_check (
    .size  (cmd_size),
    .burst (cmd_burst),
    .len   (cmd_len),
    .legal (cmd_legal)
  );

`ifdef AXI4_WM_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  always_comb wdog_d = state_q == RESP ? wdog_q + 32'd1 : '0;
  assign timeout = state_q == RESP && wdog_q == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge ACLK) wdog_q <= !ARESETn ? '0 : wdog_d;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES == 0;
  assign timeout = 1'b0;
`endif

  assign w_hs = state_q == DATA && wd_valid && axi.WREADY;
  assign last = beat_cnt_q == len_q;

  assign axi.AWVALID = state_q == ADDR;
  assign axi.AWID    = id_q;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = len_q;
  assign axi.AWSIZE  = size_q;
  assign axi.AWBURST = burst_q;
  assign axi.WVALID  = state_q == DATA && wd_valid;
  assign axi.WID     = id_q;
  assign axi.WDATA   = state_q == DATA ? wd_data : '0;
  assign axi.WSTRB   = state_q == DATA ? wd_strb : '0;
  assign axi.WLAST   = state_q == DATA && last;
  assign axi.BREADY  = state_q == RESP;
  assign wd_ready    = state_q == DATA && axi.WREADY;

  // Illegal commands and B completions both report combinationally in the cycle they occur.
  always_comb begin
    state_d = state_q;
    {addr_d, len_d, size_d, burst_d, id_d} = {addr_q, len_q, size_q, burst_q, id_q};
    beat_cnt_d = w_hs ? (last ? '0 : beat_cnt_q + 8'd1) : beat_cnt_q;
    cmd_ready = 1'b0;
    done_valid = 1'b0;
    done_id = '0;
    done_resp = OKAY;
    done_id_err = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = ARESETn;
        if (cmd_valid && ARESETn) begin
          {addr_d, len_d, size_d, burst_d, id_d} = {cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_id};
          beat_cnt_d = '0;
          state_d = cmd_legal ? ADDR : IDLE;
          done_valid = !cmd_legal;
          done_id = cmd_legal ? '0 : cmd_id;
          done_resp = cmd_legal ? OKAY : SLVERR;
        end
      end
      ADDR: state_d = axi.AWREADY ? DATA : ADDR;
      DATA: state_d = w_hs && last ? RESP : DATA;
      RESP: begin
        if (axi.BVALID || timeout) begin
          state_d = IDLE;
          done_valid = ARESETn;
          done_id = id_q;
          done_resp = axi.BVALID ? axi.BRESP : DECERR;
          done_id_err = axi.BVALID && axi.BID != id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      id_q <= id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_axi4_write_master.sv
// tb_axi4_write_master: directed self-checking bench for axi4_write_master
module tb_axi4_write_master;
  logic        ACLK;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [3:0]  cmd_id;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        done_valid, done_id_err;
  logic [3:0]  done_id;
  logic [1:0]  done_resp;
  logic [102:0] all_out;

  axi4_write_master_if axi();

  axi4_write_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .axi(axi),
    .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp), .done_id_err(done_id_err)
  );

  assign all_out = {cmd_ready, wd_ready, axi.AWVALID, axi.AWID, axi.AWADDR, axi.AWLEN, axi.AWSIZE,
                    axi.AWBURST, axi.WVALID, axi.WID, axi.WDATA, axi.WSTRB, axi.WLAST, axi.BREADY,
                    done_valid, done_id, done_resp, done_id_err};

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks, n_fail;
  int n_beats, lat;
  bit done_seen, aw_seen, aw_unstable, w_drop, overlap, wlast_bad, data_bad, extra_done;
  logic [31:0] last_data, aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst, d_resp;
  logic [3:0]  aw_id, d_id;
  logic        d_err;

  // Drives one command and a counting stream (0xA0, 0xA1, ...) and acts as the slave; records observations.
  task automatic run_txn(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [3:0] id, input logic [3:0] bid,
                         input logic [1:0] br, input int aw_stall, input bit w_tog,
                         input bit b_en, input int budget);
    int aw_cnt, acc_cyc, done_cyc;
    bit accepted, b_ok, aw_hold, w_hold, w_hs, b_hs;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;
    n_beats = 0; lat = -1; done_seen = 0; aw_seen = 0; aw_unstable = 0; w_drop = 0;
    overlap = 0; wlast_bad = 0; data_bad = 0; extra_done = 0; last_data = '0;
    aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_id = '0;
    d_resp = '0; d_id = '0; d_err = 1'b0;
    aw_cnt = 0; acc_cyc = -1; done_cyc = 0; accepted = 0; b_ok = 0; aw_hold = 0; w_hold = 0;
    hold_addr = '0; hold_len = '0;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = len; cmd_size = sz; cmd_burst = bu; cmd_id = id;
    wd_valid = 1'b1; wd_data = 32'hA0; wd_strb = 4'hF;
    axi.BID = bid; axi.BRESP = br;
    for (int cyc = 0; cyc < budget; cyc++) begin
      axi.AWREADY = aw_cnt >= aw_stall;
      axi.WREADY = w_tog ? 1'(cyc % 2) : 1'b1;
      axi.BVALID = b_ok && b_en;
      #4;
      if (cmd_valid && cmd_ready) begin accepted = 1; acc_cyc = cyc; end
      if (axi.AWVALID) begin
        aw_seen = 1; aw_cnt++;
        if (axi.WVALID) overlap = 1;
        if (aw_hold && (axi.AWADDR !== hold_addr || axi.AWLEN !== hold_len)) aw_unstable = 1;
        aw_hold = !axi.AWREADY; hold_addr = axi.AWADDR; hold_len = axi.AWLEN;
        if (axi.AWREADY) begin
          aw_addr = axi.AWADDR; aw_len = axi.AWLEN; aw_size = axi.AWSIZE;
          aw_burst = axi.AWBURST; aw_id = axi.AWID;
        end
      end else if (aw_hold) aw_unstable = 1;
      if (w_hold && !axi.WVALID) w_drop = 1;
      w_hold = axi.WVALID && !axi.WREADY;
      w_hs = axi.WVALID && axi.WREADY;
      if (w_hs) begin
        if (axi.WDATA !== wd_data || axi.WSTRB !== wd_strb || axi.WID !== id) data_bad = 1;
        n_beats++;
        if (axi.WLAST !== (n_beats == int'(len) + 1)) wlast_bad = 1;
        if (axi.WLAST) begin last_data = axi.WDATA; b_ok = 1; end
      end
      b_hs = axi.BVALID && axi.BREADY;
      if (done_valid) begin
        if (done_seen) extra_done = 1;
        done_seen = 1; done_cyc = cyc; lat = cyc - acc_cyc;
        d_resp = done_resp; d_id = done_id; d_err = done_id_err;
      end
      @(posedge ACLK); #1;
      if (accepted) cmd_valid = 1'b0;
      if (w_hs) wd_data = wd_data + 32'd1;
      if (b_hs) b_ok = 0;
      if (done_seen) wd_valid = 1'b0;
      if (done_seen && cyc >= done_cyc + 2) break;
    end
    cmd_valid = 1'b0; wd_valid = 1'b0; axi.BVALID = 1'b0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0; cmd_valid = 1'b1; cmd_addr = 32'h1234; cmd_len = 8'd3; cmd_size = 3'd2;
    cmd_burst = 2'd1; cmd_id = 4'd9; wd_valid = 1'b1; wd_data = 32'hDEAD; wd_strb = 4'hF;
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = 1'b1; axi.BID = '0; axi.BRESP = '0;
    repeat (3) @(posedge ACLK);
    #5;
    n_checks++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    cmd_valid = 1'b0; wd_valid = 1'b0; axi.BVALID = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    #4;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++;
    if ({axi.AWVALID, axi.WVALID, axi.BREADY, wd_ready, done_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_idle_valids: got %b want 00000",
                         {axi.AWVALID, axi.WVALID, axi.BREADY, wd_ready, done_valid});
    end
  endtask

  task automatic test_incr();
    run_txn(32'h1000, 8'd3, 3'd2, 2'd1, 4'd5, 4'd5, 2'd0, 0, 1'b0, 1'b1, 40);
    n_checks++;
    if (n_beats !== 4) begin n_fail++; $display("FAIL incr_beats: got %0d want 4", n_beats); end
    n_checks++;
    if (last_data !== 32'hA3) begin n_fail++; $display("FAIL incr_last_data: got %h want a3", last_data); end
    n_checks++;
    if (wlast_bad || data_bad) begin n_fail++; $display("FAIL incr_w_beats: wlast_bad %0d data_bad %0d want 0 0", wlast_bad, data_bad); end
    n_checks++;
    if ({aw_addr, aw_len, aw_size, aw_burst, aw_id} !== {32'h1000, 8'd3, 3'd2, 2'd1, 4'd5}) begin
      n_fail++; $display("FAIL incr_aw: got %h/%0d/%0d/%0d/%0d want 1000/3/2/1/5", aw_addr, aw_len, aw_size, aw_burst, aw_id);
    end
    n_checks++;
    if (!done_seen || d_resp !== 2'd0 || d_id !== 4'd5 || d_err !== 1'b0) begin
      n_fail++; $display("FAIL incr_done: seen %0d resp %0d id %0d err %0d want 1 0 5 0", done_seen, d_resp, d_id, d_err);
    end
    n_checks++;
    if (lat < 6 || lat > 8) begin n_fail++; $display("FAIL incr_latency: got %0d want 6..8", lat); end
    n_checks++;
    if (overlap || extra_done) begin n_fail++; $display("FAIL incr_protocol: overlap %0d extra_done %0d want 0 0", overlap, extra_done); end
  endtask

  task automatic test_backpressure();
    run_txn(32'h2000, 8'd3, 3'd2, 2'd1, 4'd3, 4'd3, 2'd0, 3, 1'b1, 1'b1, 60);
    n_checks++;
    if (aw_unstable || w_drop) begin n_fail++; $display("FAIL bp_stable: aw_unstable %0d w_drop %0d want 0 0", aw_unstable, w_drop); end
    n_checks++;
    if (n_beats !== 4) begin n_fail++; $display("FAIL bp_beats: got %0d want 4", n_beats); end
    n_checks++;
    if (last_data !== 32'hA3 || data_bad || wlast_bad) begin
      n_fail++; $display("FAIL bp_data: last %h data_bad %0d wlast_bad %0d want a3 0 0", last_data, data_bad, wlast_bad);
    end
    n_checks++;
    if (!done_seen || d_resp !== 2'd0 || overlap) begin
      n_fail++; $display("FAIL bp_done: seen %0d resp %0d overlap %0d want 1 0 0", done_seen, d_resp, overlap);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] bursts [3] = '{2'd3, 2'd2, 2'd1};
    logic [7:0] lens   [3] = '{8'd3, 8'd5, 8'd1};
    logic [2:0] sizes  [3] = '{3'd2, 3'd2, 3'd3};
    for (int i = 0; i < 3; i++) begin
      run_txn(32'h3000, lens[i], sizes[i], bursts[i], 4'(6 + i), 4'(6 + i), 2'd0, 0, 1'b0, 1'b1, 20);
      n_checks++;
      if (!done_seen || lat !== 0 || d_resp !== 2'd2 || d_id !== 4'(6 + i)) begin
        n_fail++; $display("FAIL illegal_%0d_done: seen %0d lat %0d resp %0d id %0d want 1 0 2 %0d", i, done_seen, lat, d_resp, d_id, 6 + i);
      end
      n_checks++;
      if (aw_seen || n_beats !== 0) begin
        n_fail++; $display("FAIL illegal_%0d_bus: aw_seen %0d beats %0d want 0 0", i, aw_seen, n_beats);
      end
    end
  endtask

  task automatic test_wrap();
    run_txn(32'h5000, 8'd7, 3'd2, 2'd2, 4'd2, 4'd2, 2'd0, 0, 1'b0, 1'b1, 40);
    n_checks++;
    if (n_beats !== 8 || last_data !== 32'hA7 || aw_burst !== 2'd2) begin
      n_fail++; $display("FAIL wrap8: beats %0d last %h burst %0d want 8 a7 2", n_beats, last_data, aw_burst);
    end
  endtask

  task automatic test_edges();
    run_txn(32'h6000, 8'd0, 3'd0, 2'd0, 4'd1, 4'd1, 2'd0, 0, 1'b0, 1'b1, 30);
    n_checks++;
    if (n_beats !== 1 || wlast_bad || last_data !== 32'hA0) begin
      n_fail++; $display("FAIL len0: beats %0d wlast_bad %0d last %h want 1 0 a0", n_beats, wlast_bad, last_data);
    end
    run_txn(32'h7000, 8'd255, 3'd2, 2'd1, 4'd4, 4'd4, 2'd0, 0, 1'b0, 1'b1, 400);
    n_checks++;
    if (n_beats !== 256 || wlast_bad || last_data !== 32'h19F) begin
      n_fail++; $display("FAIL len255: beats %0d wlast_bad %0d last %h want 256 0 19f", n_beats, wlast_bad, last_data);
    end
    n_checks++;
    if (!done_seen || d_resp !== 2'd0) begin n_fail++; $display("FAIL len255_done: seen %0d resp %0d want 1 0", done_seen, d_resp); end
    run_txn(32'h8000, 8'd1, 3'd2, 2'd1, 4'd5, 4'd7, 2'd1, 0, 1'b0, 1'b1, 30);
    n_checks++;
    if (!done_seen || d_err !== 1'b1 || d_id !== 4'd5 || d_resp !== 2'd1) begin
      n_fail++; $display("FAIL bid_mismatch: seen %0d err %0d id %0d resp %0d want 1 1 5 1", done_seen, d_err, d_id, d_resp);
    end
  endtask

  task automatic test_reset_mid();
    int beats;
    bit acc, hs, saw_done;
    beats = 0; acc = 0; saw_done = 0;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h4000; cmd_len = 8'd3; cmd_size = 3'd2; cmd_burst = 2'd1; cmd_id = 4'hA;
    wd_valid = 1'b1; wd_data = 32'hA0; wd_strb = 4'hF;
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = 1'b0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      #4;
      if (cmd_valid && cmd_ready) acc = 1;
      hs = axi.WVALID && axi.WREADY;
      if (hs) beats++;
      if (done_valid) saw_done = 1;
      @(posedge ACLK); #1;
      if (acc) cmd_valid = 1'b0;
      if (hs) wd_data = wd_data + 32'd1;
    end
    ARESETn = 1'b0;
    #4;
    if (done_valid) saw_done = 1;
    @(posedge ACLK); #4;
    n_checks++;
    if (all_out !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h want 0", all_out); end
    @(posedge ACLK); #1;
    ARESETn = 1'b1; wd_valid = 1'b0;
    #4;
    if (done_valid) saw_done = 1;
    n_checks++;
    if (saw_done || beats !== 2) begin n_fail++; $display("FAIL midrst_no_done: done %0d beats %0d want 0 2", saw_done, beats); end
    run_txn(32'h4100, 8'd1, 3'd2, 2'd1, 4'hB, 4'hB, 2'd0, 0, 1'b0, 1'b1, 40);
    n_checks++;
    if (n_beats !== 2 || !done_seen || d_resp !== 2'd0 || d_id !== 4'hB) begin
      n_fail++; $display("FAIL midrst_next: beats %0d seen %0d resp %0d id %0d want 2 1 0 11", n_beats, done_seen, d_resp, d_id);
    end
  endtask

  task automatic test_watchdog();
    run_txn(32'h9000, 8'd0, 3'd2, 2'd1, 4'd3, 4'd3, 2'd0, 0, 1'b0, 1'b0, 100);
    n_checks++;
`ifdef AXI4_WM_TIMEOUT_EN
    if (!done_seen || d_resp !== 2'd3 || d_err !== 1'b0 || lat < 18 || lat > 19) begin
      n_fail++; $display("FAIL watchdog: seen %0d resp %0d err %0d lat %0d want 1 3 0 18..19", done_seen, d_resp, d_err, lat);
    end
`else
    if (done_seen) begin n_fail++; $display("FAIL no_watchdog: done seen %0d want 0", done_seen); end
`endif
    n_checks++;
    if (n_beats !== 1) begin n_fail++; $display("FAIL watchdog_beats: got %0d want 1", n_beats); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_incr();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_edges();
    test_reset_mid();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
